mfp_hr_beat_window: RTL
=======================

Name: mfp_hr_beat_window

Overview:
- Upstream producer for the CPU-side counter peripheral. Counts debounced heartbeat pulses from the pulse sensor over a fixed measurement window (6 s default).
- At each window expiry it publishes the beat count and the derived BPM on `time_is_up`, and raises a ready flag.
- The ready flag holds until the CPU acknowledges through `cpu_cnt_reset`.
- Free-running: the next window starts the cycle after expiry, so no window time is lost.

Parameters:
- CLK_FREQ_HZ, 50000000, HCLK frequency in Hz.
- WINDOW_SEC, 6, measurement window length in seconds. BPM scale factor = 60/WINDOW_SEC, which must be an integer.
- REFRACT_CYCLES, 10000000, minimum cycles between counted beats (200 ms at default clock). Rejects double-counting.

Ports:
- HCLK  input  1  system clock.
- HRESET  input  1  asynchronous, active-high reset.
- beat_in  input  1  raw pulse-sensor beat level, asynchronous to HCLK.
- cpu_cnt_reset  input  1  CPU acknowledge level. A rising edge clears ready/overrun.
- time_is_up  output  32  status word:
  - [31] ready
  - [30] overrun
  - [29:16] bpm, saturating at 14'h3FFF
  - [15:0] beat count, saturating at 16'hFFFF
- window_tick  output  1  one-cycle pulse on the cycle each window closes.

Behaviour:
- Reset (HRESET=1, async):
  - time_is_up=0, window_tick=0.
  - Window timer=0, live beat counter=0, beat FSM=ARMED.
  - Synchronizer flops and ack-edge flop=0.
- beat_in path:
  - 2-flop synchronizer, then rising-edge detect on the synchronized value.
  - Detected edge to counter increment latency: 3 cycles from the beat_in transition sampled.
- Beat FSM:
  - ARMED: a synchronized rising edge increments the live counter (saturating at 16'hFFFF) and moves to REFRACT, loading the refractory timer with REFRACT_CYCLES-1.
  - REFRACT: edges are ignored. The timer decrements each cycle. At 0, move to ARMED.
  - The FSM is independent of window boundaries: refractory time carries across a window close.
- Window timer:
  - Counts 0..CLK_FREQ_HZ*WINDOW_SEC-1; width = clog2 of that product.
  - On the terminal count: timer wraps to 0, window_tick=1 for that cycle, and the publish occurs on the same edge.
- Publish (registered; visible the cycle after window_tick):
  - count field = live count, including any beat incremented on the terminal cycle.
  - bpm = count*(60/WINDOW_SEC). Compute with shift/add only, no multiplier. Saturate at 14'h3FFF.
  - ready=1.
  - overrun=1 if ready was already 1 before this publish; otherwise overrun holds.
  - Live counter restarts at 0. If a counted beat lands on the terminal cycle, it belongs to the closing window and the new window starts at 0.
- Acknowledge:
  - Register cpu_cnt_reset and detect its rising edge.
  - The edge clears ready and overrun only; count and bpm fields hold.
  - A level held high causes no further clears.
- Simultaneous ack edge and publish: publish wins. ready=1, and overrun=0 (the prior result is treated as acknowledged).
- Reset mid-window: all state is discarded, and the first window after release is a full-length window.

Test Plan:
- CLK_FREQ_HZ=100, WINDOW_SEC=6, REFRACT_CYCLES=5 (window = 600 cycles), used for all scenarios:
  1. 7 beat pulses spaced 20 cycles apart within the first window -> at cycle 600 window_tick=1; next cycle time_is_up = 32'h8046_0007 (ready, bpm=70, count=7).
  2. 2 edges 3 cycles apart, then 1 edge 10 cycles later -> count=2 (the second edge is in refractory).
  3. No ack across two windows with 1 beat each -> second publish shows ready=1, overrun=1, count=1. A cpu_cnt_reset 0->1 then gives bits[31:30]=0 with count=1 held. Holding cpu_cnt_reset at 1 for the next publish gives ready=1 after that publish.
  4. cpu_cnt_reset rising edge timed to land on the publish cycle, with ready previously 1 -> ready=1, overrun=0.
  5. Beat edge timed so its increment lands on the terminal cycle -> counted in the closing window; the next window's count excludes it.
  6. HRESET asserted at window cycle 300 after 3 beats -> time_is_up=0 immediately (async). The first tick occurs 600 cycles after release.

Source files
------------

// File: rtl/mfp_hr_beat_window.sv
`default_nettype none
// ============================================================================
// Module   : mfp_hr_beat_window
// Purpose  : Counts debounced heartbeat pulses over a fixed window and
//            publishes beat count and BPM to the CPU-side status word.
// Revision : 1.0 - initial release
// ============================================================================
module mfp_hr_beat_window #(
    parameter int CLK_FREQ_HZ    = 50000000,
    parameter int WINDOW_SEC     = 6,
    parameter int REFRACT_CYCLES = 10000000
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        beat_in,
    input  logic        cpu_cnt_reset,
    output logic [31:0] time_is_up,
    output logic        window_tick
);

    localparam int c_WIN_CYCLES = CLK_FREQ_HZ * WINDOW_SEC;
    localparam int c_TW         = (c_WIN_CYCLES > 1) ? $clog2(c_WIN_CYCLES) : 1;
    localparam int c_RW         = (REFRACT_CYCLES > 1) ? $clog2(REFRACT_CYCLES) : 1;
    localparam logic [c_TW-1:0] c_WIN_LAST     = c_TW'(c_WIN_CYCLES - 1);
    localparam logic [c_RW-1:0] c_REFRACT_LOAD = c_RW'(REFRACT_CYCLES - 1);
    localparam logic [5:0]      c_SCALE        = 6'(60 / WINDOW_SEC);

    localparam logic [0:0] ST_ARMED   = 1'b0;
    localparam logic [0:0] ST_REFRACT = 1'b1;

    logic            r_sync1, r_sync2, r_sync3, r_rise;
    logic            r_ack_d;
    logic [0:0]      r_state, w_state_next;
    logic [c_RW-1:0] r_refract, w_refract_next;
    logic            w_inc;
    logic [15:0]     r_live, w_cnt_inc;
    logic [c_TW-1:0] r_timer;
    logic            w_tick;
    logic            w_ack_rise;
    logic [21:0]     w_bpm_full;
    logic [13:0]     w_bpm;
    logic            r_ready, r_overrun;
    logic [13:0]     r_bpm;
    logic [15:0]     r_count;

    // Two-flop synchronizer, a delayed copy for edge detect, and a registered
    // rise pulse so a sampled transition reaches the counter three cycles later.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
            r_rise  <= 1'b0;
            r_ack_d <= 1'b0;
        end else begin
            r_sync1 <= beat_in;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_rise  <= r_sync2 & ~r_sync3;
            r_ack_d <= cpu_cnt_reset;
        end
    end

    assign w_ack_rise = cpu_cnt_reset & ~r_ack_d;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state   <= ST_ARMED;
            r_refract <= '0;
        end else begin
            r_state   <= w_state_next;
            r_refract <= w_refract_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_refract_next = r_refract;
        w_inc          = 1'b0;
        case (r_state)
            ST_ARMED: begin
                if (r_rise) begin
                    w_inc          = 1'b1;
                    w_state_next   = ST_REFRACT;
                    w_refract_next = c_REFRACT_LOAD;
                end
            end
            ST_REFRACT: begin
                if (r_refract == '0) begin
                    w_state_next = ST_ARMED;
                end else begin
                    w_refract_next = r_refract - 1'b1;
                end
            end
        endcase
    end

    assign w_cnt_inc = (w_inc && (r_live != 16'hFFFF)) ? r_live + 16'd1 : r_live;
    assign w_tick    = (r_timer == c_WIN_LAST);

    // A beat counted on the terminal cycle belongs to the closing window.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_timer <= '0;
            r_live  <= '0;
        end else begin
            r_timer <= w_tick ? '0 : r_timer + 1'b1;
            r_live  <= w_tick ? '0 : w_cnt_inc;
        end
    end

    // Constant-coefficient multiply as a sum of shifted copies of the count.
    always_comb begin
        w_bpm_full = '0;
        for (int i = 0; i < 6; i++) begin
            if (c_SCALE[i]) begin
                w_bpm_full = w_bpm_full + ({6'd0, w_cnt_inc} << i);
            end
        end
    end

    assign w_bpm = (w_bpm_full > 22'd16383) ? 14'h3FFF : w_bpm_full[13:0];

    // Publish outranks acknowledge; a coincident ack marks the prior result as read.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_ready   <= 1'b0;
            r_overrun <= 1'b0;
            r_bpm     <= '0;
            r_count   <= '0;
        end else if (w_tick) begin
            r_ready   <= 1'b1;
            r_overrun <= w_ack_rise ? 1'b0 : (r_overrun | r_ready);
            r_bpm     <= w_bpm;
            r_count   <= w_cnt_inc;
        end else if (w_ack_rise) begin
            r_ready   <= 1'b0;
            r_overrun <= 1'b0;
        end
    end

    assign time_is_up  = {r_ready, r_overrun, r_bpm, r_count};
    assign window_tick = w_tick;

endmodule
`default_nettype wire
